// File: rtl/fpu_result_fifo.sv
// First-word-fall-through result FIFO behind the FPU stage: buffers each result
// with its op tag and IEEE-754 class flags, and flags any result dropped while full.
`timescale 1ns/1ps
module fpu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      In_Data,
  input  logic             In_Data_Valid,
  input  logic             In_Op,
  input  logic             Out_Ready,
  input  logic             Clr_Ovf,
  output logic [31:0]      Data_Out,
  output logic             Out_Op,
  output logic [2:0]       Out_Flags,
  output logic             Out_Data_Valid,
  output logic [CNT_W-1:0] Count,
  output logic             Full,
  output logic             Overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // {nan, inf, zero}; sign is irrelevant to the class, so only exponent and mantissa come in
  function automatic logic [2:0] classify(input logic [30:0] mag);
    logic [7:0]  e;
    logic [22:0] m;
    logic        nan, inf, zero;
    e    = mag[30:23];
    m    = mag[22:0];
    nan  = (e == 8'hFF) && (m != 23'd0);
    inf  = (e == 8'hFF) && (m == 23'd0);
    zero = (e == 8'd0)  && (m == 23'd0);
    return {nan, inf, zero};
  endfunction

  logic [31:0]      data_mem [DEPTH];
  logic             op_mem   [DEPTH];
  logic [2:0]       flag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic             pop, push, drop, wr_en;
  logic [2:0]       in_flags_p0;

  assign Full           = (count_q == CNT_W'(DEPTH));
  assign Out_Data_Valid = (count_q != '0);
  assign Count          = count_q;
  assign Overflow       = ovf_q;

  assign pop         = Out_Data_Valid && Out_Ready;
  assign push        = In_Data_Valid && (!Full || pop);
  assign drop        = In_Data_Valid && Full && !pop;
  assign wr_en       = push && !Reset;
  assign in_flags_p0 = classify(In_Data[30:0]);

  // Head entry falls through straight from storage; contents are meaningless when empty
  assign Data_Out  = data_mem[rd_ptr];
  assign Out_Op    = op_mem[rd_ptr];
  assign Out_Flags = flag_mem[rd_ptr];

  // Storage carries data only and is never reset
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      data_mem[wr_ptr] <= In_Data;
      op_mem[wr_ptr]   <= In_Op;
      flag_mem[wr_ptr] <= in_flags_p0;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      // A fresh drop outranks a clear in the same cycle
      if (drop)         ovf_q <= 1'b1;
      else if (Clr_Ovf) ovf_q <= 1'b0;
    end
  end

endmodule
